barrel_shift_right_pipe: RTL and testbench
==========================================

Name: barrel_shift_right_pipe

Overview:
Pipelined 32-bit right barrel shifter with logical or arithmetic fill. It is the right-shift counterpart of the team's combinational left barrel shifter. Each power-of-two shift step (16, 8, 4, 2, 1) sits in its own registered stage. A valid/ready handshake provides full throughput (one operand per clock) and backpressure, so the block can sit between the messenger's bit-packing logic and downstream consumers.

Parameters:
WIDTH, 32, data width in bits; must be a power of two, minimum 2.
AMT_W, 5, shift-amount width; must equal log2(WIDTH); also the number of pipeline stages.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand present on in_data/in_amt/in_arith
in_ready  output  1  block accepts the operand this cycle
in_data  input  WIDTH  value to shift
in_amt  input  AMT_W  right-shift amount, 0..WIDTH-1
in_arith  input  1  1 = fill vacated bits with in_data[WIDTH-1]; 0 = fill with zeros
out_valid  output  1  out_data holds a result
out_ready  input  1  consumer takes the result this cycle
out_data  output  WIDTH  shifted result

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - Every stage valid flag = 0, so out_valid = 0.
  - Every stage data register = 0, so out_data = 0.
  - in_ready = 0 while reset is asserted.
- Pipeline advance: global enable adv = !out_valid || out_ready.
  - in_ready = adv while reset is deasserted.
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
- Stage i (i = 0..AMT_W-1) handles shift step 2^(AMT_W-1-i): stage 0 shifts by 16, stage 4 by 1.
- Each stage register holds:
  - data
  - the remaining lower amount bits
  - the arith flag
  - the sign bit, captured from in_data[WIDTH-1] at stage 0 and carried forward
  - a valid flag
- On adv, each stage loads from its predecessor. The stage shifts by its step when its amount bit is 1, otherwise it passes data through. Vacated MSBs are filled with (arith ? sign : 0).
- When adv = 0, all stages hold their contents.
- Bubbles are carried: on adv with no transfer in, stage 0 loads valid = 0. Bubbles are not squeezed out.
- Latency: an operand accepted on edge k appears with out_valid = 1 after edge k+AMT_W-1, i.e. 5 edges counting the accepting edge. Throughput is 1 per clock when out_ready is held at 1.
- Ordering: results leave in acceptance order. None are dropped or duplicated.
- Stall: while out_valid = 1 and out_ready = 0:
  - out_data and out_valid are stable.
  - in_ready = 0.
  - Upstream holds its operand.
- Boundary conditions:
  - in_amt = 0: out_data = in_data, for either arith value.
  - in_amt = WIDTH-1, logical: out_data = {0..., in_data[WIDTH-1]}.
  - in_amt = WIDTH-1, arith: all bits equal to the sign bit.
  - arith with a positive operand gives the same result as logical.
- Simultaneous transfer in and transfer out in one cycle is legal. The pipeline advances by exactly one.
- Reset mid-operation: all in-flight results are discarded immediately. out_valid drops asynchronously. No stale result appears after reset is released.
- Invalid stages may hold any data, but must not toggle out_valid.

Decomposition:
- Shared constants include file: DATA_W = 32 and AMT_W = 5. barrel_shift_right_pipe and the existing left shifter both use it.
- One sub-module, shift_right_stage, parameterised by STEP. It contains:
  - the conditional shift-by-STEP combinational logic with fill
  - the stage register for data, amount bits, arith, sign and valid, with adv enable and async reset
- The top level instantiates AMT_W copies and computes adv, in_ready and the outputs.

Test Plan:
1. Logical full shift: in_data = 0x80000000, amt = 31, arith = 0, out_ready = 1 -> out_data = 0x00000001, out_valid rises 5 edges after acceptance.
2. Arith vs logical: in_data = 0x80000000, amt = 4, arith = 1 -> 0xF8000000. Same operand with arith = 0 -> 0x08000000. Also 0x7FFFFFFF, amt = 4, arith = 1 -> 0x07FFFFFF.
3. Pass-through: in_data = 0xDEADBEEF, amt = 0, with arith = 0 and again with arith = 1 -> 0xDEADBEEF both times.
4. Streaming: 8 back-to-back operands (0x12345678 >> 0..7 logical), out_ready = 1 -> 8 results on consecutive cycles, in order, each matching the expected value.
5. Backpressure: fill the pipe, hold out_ready = 0 for 3 cycles, then release -> in_ready = 0 and out_data stable during the stall; full sequence afterwards with no loss or duplication.
6. Reset mid-stream: assert reset with 3 operands in flight -> out_valid = 0 and out_data = 0 immediately. After release, in_ready = 1 and no output until a new operand is accepted.

Source files
------------

// File: rtl/barrel_shift_right_pipe_pkg.sv
// Shared constants for the right barrel shifter pipeline.
// Holds DATA_W/AMT_W and a stage-step helper; imported by the shifter files.
package barrel_shift_right_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Shift step handled by pipeline stage idx: the MSB of the amount first.
    function automatic int step_of(input int idx, input int amt_w);
        return 1 << (amt_w - 1 - idx);
    endfunction

endpackage

// File: rtl/barrel_shift_right_pipe_if.sv
// Valid/ready operand and result bundle for barrel_shift_right_pipe.
// slave: shifter view (takes operands, drives results); master: producer/consumer view.
interface barrel_shift_right_pipe_if #(
    parameter int WIDTH = barrel_shift_right_pipe_pkg::DATA_W,
    parameter int AMT_W = barrel_shift_right_pipe_pkg::AMT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_amt, in_arith, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_amt, in_arith, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_right_stage.sv
// One registered step of the right shifter: optional shift by STEP with fill.
// Ports: clk, reset, adv_i enable; *_i from previous stage, *_o registered.
module shift_right_stage #(
    parameter int WIDTH = barrel_shift_right_pipe_pkg::DATA_W,
    parameter int AMT_W = barrel_shift_right_pipe_pkg::AMT_W,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             arith_i,
    input  logic             sign_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [AMT_W-1:0] amt_o,
    output logic             arith_o,
    output logic             sign_o
);
    localparam int BIT = $clog2(STEP);
    localparam logic [WIDTH-1:0] ONES = '1;
    // Bits vacated by a shift of STEP.
    localparam logic [WIDTH-1:0] FILL_MASK = ~(ONES >> STEP);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [AMT_W-1:0] amt_q;
    logic             arith_q;
    logic             sign_q;
    logic             fill;

    assign fill = arith_i & sign_i;

    always_comb begin
        data_d = data_i;
        if (amt_i[BIT]) begin
            data_d = (data_i >> STEP) | (fill ? FILL_MASK : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            amt_q   <= amt_i;
            arith_q <= arith_i;
            sign_q  <= sign_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign arith_o = arith_q;
    assign sign_o  = sign_q;
endmodule

// File: rtl/barrel_shift_right_pipe.sv
// Pipelined right barrel shifter, logical or arithmetic, one step per stage.
// Ports: clk, reset (async, active-high), bus (slave side of the valid/ready bundle).
module barrel_shift_right_pipe #(
    parameter int WIDTH = barrel_shift_right_pipe_pkg::DATA_W,
    parameter int AMT_W = barrel_shift_right_pipe_pkg::AMT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    barrel_shift_right_pipe_if.slave bus
);
    // Index 0 is the incoming operand; index i+1 is the register of stage i.
    logic             v  [0:AMT_W];
    logic [WIDTH-1:0] d  [0:AMT_W];
    logic [AMT_W-1:0] a  [0:AMT_W];
    logic             ar [0:AMT_W];
    logic             sg [0:AMT_W];
    logic             adv;

    // The whole pipe moves together; bubbles are carried, not squeezed.
    assign adv          = !v[AMT_W] || bus.out_ready;
    assign bus.in_ready = adv && !reset;

    assign v[0]  = bus.in_valid && bus.in_ready;
    assign d[0]  = bus.in_data;
    assign a[0]  = bus.in_amt;
    assign ar[0] = bus.in_arith;
    assign sg[0] = bus.in_data[WIDTH-1];

    for (genvar i = 0; i < AMT_W; i++) begin : g_stage
        shift_right_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .STEP  (barrel_shift_right_pipe_pkg::step_of(i, AMT_W))
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (adv),
            .valid_i (v[i]),
            .data_i  (d[i]),
            .amt_i   (a[i]),
            .arith_i (ar[i]),
            .sign_i  (sg[i]),
            .valid_o (v[i+1]),
            .data_o  (d[i+1]),
            .amt_o   (a[i+1]),
            .arith_o (ar[i+1]),
            .sign_o  (sg[i+1])
        );
    end

    assign bus.out_valid = v[AMT_W];
    assign bus.out_data  = d[AMT_W];
endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Directed scoreboard bench for barrel_shift_right_pipe.
// Inputs change on negedge; outputs are sampled 1 time unit before posedge.
module tb_barrel_shift_right_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] sb[$];
    int pop_cyc[$];

    always #5 clk = ~clk;

    barrel_shift_right_pipe_if #(.WIDTH(32), .AMT_W(5)) bus ();

    barrel_shift_right_pipe #(.WIDTH(32), .AMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic ar);
        logic signed [31:0] s;
        s = d;
        if (ar) return s >>> a;
        return d >> a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every transfer out.
    always @(negedge clk) begin
        #4;
        cyc++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_out: observed %h expected none", bus.out_data);
            end else begin
                check("out_data", bus.out_data, sb.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic ar);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_arith = ar;
        #1;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready %b expected 1", bus.in_ready);
        end else begin
            sb.push_back(model(d, a, ar));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_amt   = 5'd0;
        bus.in_arith = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        idle();
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", {31'b0, bus.in_ready}, 32'h1);

        // 1: logical full shift and latency
        send(32'h8000_0000, 5'd31, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lat_out_valid_low", {31'b0, bus.out_valid}, 32'h0);
            @(negedge clk);
        end
        #1;
        check("lat_out_valid_high", {31'b0, bus.out_valid}, 32'h1);
        drain();

        // 2: arith vs logical; 3: pass-through; boundaries
        send(32'h8000_0000, 5'd4, 1'b1);
        send(32'h8000_0000, 5'd4, 1'b0);
        send(32'h7FFF_FFFF, 5'd4, 1'b1);
        send(32'hDEAD_BEEF, 5'd0, 1'b0);
        send(32'hDEAD_BEEF, 5'd0, 1'b1);
        send(32'h8765_4321, 5'd31, 1'b1);
        send(32'h8765_4321, 5'd31, 1'b0);
        send(32'hC000_0001, 5'd17, 1'b1);
        send(32'h5A5A_5A5A, 5'd13, 1'b1);
        idle();
        drain();

        // 4: streaming, results on consecutive cycles
        n = pop_cyc.size();
        for (int i = 0; i < 8; i++) send(32'h1234_5678, 5'(i), 1'b0);
        idle();
        drain();
        check("stream_count", 32'(pop_cyc.size() - n), 32'd8);
        if (pop_cyc.size() - n == 8)
            check("stream_span", 32'(pop_cyc[n+7] - pop_cyc[n]), 32'd7);

        // 5: backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'hF0F0_1234 ^ 32'(i), 5'(3 * i + 1), i[0]);
        idle();
        #1;
        held = bus.out_data;
        check("stall_first", held, model(32'hF0F0_1234, 5'd1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
            check("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
            check("stall_out_data", bus.out_data, held);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drain();

        // 6: reset mid-stream
        send(32'hAAAA_5555, 5'd1, 1'b1);
        send(32'hAAAA_5555, 5'd2, 1'b1);
        send(32'hAAAA_5555, 5'd3, 1'b1);
        idle();
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("mid_rst_out_data", bus.out_data, 32'h0);
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_out", {31'b0, bus.out_valid}, 32'h0);
        end
        @(negedge clk);
        send(32'h0000_00F0, 5'd4, 1'b0);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
